// File: rtl/singleportram_ctrl.sv
// Access controller for the 16x8 single-port RAM.
// Commands arrive over valid/ready and are queued in a small FIFO. The FSM
// runs them in order, inserting one IDLE cycle between operations so the
// shared data bus always turns around. Read data comes back on rsp_*.
module singleportram_ctrl #(
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic [AW-1:0] ram_wr_addr,
  output logic [AW-1:0] ram_rd_addr,
  output logic          ram_we,
  output logic          ram_re,
  inout  wire logic [DW-1:0] ram_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 1 + AW + DW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RD_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0] fifo_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic          ram_we_q, ram_we_d;
  logic          ram_re_q, ram_re_d;
  logic [AW-1:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [AW-1:0] ram_rd_addr_q, ram_rd_addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [AW-1:0] rsp_addr_q, rsp_addr_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic          head_wr;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign push      = req_valid && !full;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign head      = fifo_mem_q[rd_ptr_q];
  assign head_wr   = head[EW-1];
  assign head_addr = head[EW-2 -: AW];
  assign head_data = head[DW-1:0];

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {req_wr, req_addr, req_wdata};
    end
  end

  // FIFO pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Next state and next registered RAM/response outputs. RAM controls are
  // derived from the upcoming state so they line up with the state register.
  always_comb begin
    state_d       = state_q;
    ram_we_d      = 1'b0;
    ram_re_d      = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_rd_addr_d = ram_rd_addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_addr_d    = rsp_addr_q;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (head_wr) begin
            state_d       = ST_WRITE;
            ram_we_d      = 1'b1;
            ram_wr_addr_d = head_addr;
            wdata_d       = head_data;
          end else begin
            state_d       = ST_READ;
            ram_re_d      = 1'b1;
            ram_rd_addr_d = head_addr;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_READ: begin
        state_d  = ST_RD_WAIT;
        ram_re_d = 1'b1;
      end
      ST_RD_WAIT: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_addr_d  = ram_rd_addr_q;
        rsp_rdata_d = ram_data;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, FIFO control and all output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ram_we_q      <= 1'b0;
      ram_re_q      <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_rd_addr_q <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ram_we_q      <= ram_we_d;
      ram_re_q      <= ram_re_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  // Bus is driven only for a write; the async reset of ram_we_q releases it.
  assign ram_data = (ram_we_q && !ram_re_q) ? wdata_q : 'z;

  assign req_ready   = !full;
  assign busy        = (count_q != '0) || (state_q != ST_IDLE);
  assign ram_we      = ram_we_q;
  assign ram_re      = ram_re_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_rd_addr = ram_rd_addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_singleportram_ctrl.sv
// Bench for singleportram_ctrl: behavioural 16x8 RAM on the shared bus,
// scoreboard queues for expected writes and read responses.
module tb_singleportram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [3:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [3:0] ram_wr_addr;
  logic [3:0] ram_rd_addr;
  logic       ram_we;
  logic       ram_re;
  wire  [7:0] ram_data;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       wq[$];
  ent_t       rq[$];
  logic [7:0] exp_mem [16];
  bit         saw_full = 1'b0;

  always #5 clk = ~clk;

  singleportram_ctrl #(.AW(4), .DW(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_addr   (rsp_addr),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .ram_wr_addr(ram_wr_addr),
    .ram_rd_addr(ram_rd_addr),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_data   (ram_data)
  );

  // Undriven bus reads as all ones, so a released bus shows up as 8'hFF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (ram_data[i]);
  end

  // Behavioural RAM: write at the edge, registered read output driven while re.
  logic [7:0] ram_mem [16];
  logic [7:0] ram_dout;
  always @(posedge clk) begin
    if (ram_we && !ram_re) ram_mem[ram_wr_addr] <= ram_data;
    if (ram_re) ram_dout <= ram_mem[ram_rd_addr];
  end
  assign ram_data = (ram_re && !ram_we) ? ram_dout : 'z;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: RAM-side protocol and response scoreboard, sampled mid-cycle.
  bit prev_we = 1'b0;
  bit prev_re = 1'b0;
  int unsigned we_run = 0;
  int unsigned re_run = 0;
  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      prev_we = 1'b0;
      prev_re = 1'b0;
      we_run  = 0;
      re_run  = 0;
    end else begin
      if (rsp_valid) begin
        if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = rq.pop_front();
          chk("rsp_addr", 32'(rsp_addr), 32'(e.a));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
        end
      end
      if (ram_we) begin
        if (wq.size() == 0) chk("we_unexpected", 32'(ram_we), 32'd0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", 32'(ram_wr_addr), 32'(e.a));
          chk("wr_bus", 32'(ram_data), 32'(e.d));
        end
      end
      if (!ram_we && !ram_re) chk("bus_z_idle", 32'(ram_data), 32'hFF);
      chk("turnaround", 32'({prev_we && ram_re, prev_re && ram_we, ram_we && ram_re}), 32'd0);
      if (prev_we && !ram_we) chk("we_len", we_run, 1);
      if (prev_re && !ram_re) chk("re_len", re_run, 2);
      we_run  = ram_we ? we_run + 1 : 0;
      re_run  = ram_re ? re_run + 1 : 0;
      prev_we = ram_we;
      prev_re = ram_re;
    end
  end

  // Present one command and hold it until accepted; queue its expectation.
  task automatic send(input bit wr, input logic [3:0] a, input logic [7:0] d);
    int unsigned guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && guard < 100) begin
      saw_full = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    if (wr) begin
      wq.push_back('{a: a, d: d});
      exp_mem[a] = d;
    end else begin
      rq.push_back('{a: a, d: exp_mem[a]});
    end
  endtask

  task automatic drop();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_re"}, 32'(ram_re), 32'd0);
    chk({tag, "_wr_addr"}, 32'(ram_wr_addr), 32'd0);
    chk({tag, "_rd_addr"}, 32'(ram_rd_addr), 32'd0);
    chk({tag, "_bus"}, 32'(ram_data), 32'hFF);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset from time zero, then a mid-idle asynchronous reset.
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset_outputs("rst_idle");
    @(negedge clk);
    rst = 1'b1;

    // Write 5 <= 0F, then a read from an idle, empty controller.
    send(1'b1, 4'd5, 8'h0F);
    drop();
    chk("busy_after_write", 32'(busy), 32'd1);
    wait_idle();
    send(1'b0, 4'd5, 8'h00);
    drop();
    @(posedge clk); #1 chk("lat_e1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 chk("lat_e2", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 chk("lat_e3", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1 chk("lat_e4", 32'(rsp_valid), 32'd0);
    chk("rsp_hold_addr", 32'(rsp_addr), 32'd5);
    chk("rsp_hold_data", 32'(rsp_rdata), 32'h0F);
    wait_idle();

    // Two slow reads build a backlog, then six writes held back-to-back.
    saw_full = 1'b0;
    send(1'b0, 4'd5, 8'h00);
    send(1'b0, 4'd5, 8'h00);
    for (int unsigned i = 0; i < 6; i++) send(1'b1, 4'(i), 8'hA0 + 8'(i));
    drop();
    chk("fifo_full_seen", 32'(saw_full), 32'd1);
    wait_idle();
    for (int unsigned i = 0; i < 6; i++) send(1'b0, 4'(i), 8'h00);
    drop();
    wait_idle();

    // Alternating write/read to address 15, back-to-back.
    send(1'b1, 4'd15, 8'h3C);
    send(1'b0, 4'd15, 8'h00);
    send(1'b1, 4'd15, 8'hC3);
    send(1'b0, 4'd15, 8'h00);
    send(1'b1, 4'd15, 8'h5A);
    send(1'b0, 4'd15, 8'h00);
    drop();
    wait_idle();

    // Keep the FIFO full so pushes stall while pops drain it.
    saw_full = 1'b0;
    for (int unsigned i = 0; i < 8; i++) send(1'b0, 4'(i % 6), 8'h00);
    send(1'b1, 4'd7, 8'h77);
    send(1'b0, 4'd7, 8'h00);
    drop();
    chk("fifo_full_seen2", 32'(saw_full), 32'd1);
    wait_idle();

    // Reset while the read of address 3 is in RD_WAIT.
    send(1'b1, 4'd3, 8'h33);
    drop();
    wait_idle();
    send(1'b0, 4'd3, 8'h00);
    drop();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rdw_rst_re", 32'(ram_re), 32'd0);
    chk("rdw_rst_bus", 32'(ram_data), 32'hFF);
    chk("rdw_rst_busy", 32'(busy), 32'd0);
    chk("rdw_rst_ready", 32'(req_ready), 32'd1);
    rq.delete();
    @(posedge clk); #1 chk("rdw_rst_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send(1'b1, 4'd3, 8'h55);
    send(1'b0, 4'd3, 8'h00);
    drop();
    wait_idle();

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
